// File: rtl/conv_3x3_sched_if.sv
// Handshake and memory/tile bus of the 3x3 convolution layer sequencer.
// The master side is the sequencer; the slave side is the memories plus the conv tile.
interface conv_3x3_sched_if #(
    parameter int DATA_WIDTH = 32,
    parameter int PXL_AW     = 16,
    parameter int WGT_AW     = 20,
    parameter int CO_W       = 8
);
    logic                  start;
    logic                  busy;
    logic                  done;
    logic                  wgt_rd_en;
    logic [WGT_AW-1:0]     wgt_rd_addr;
    logic [DATA_WIDTH-1:0] wgt_rd_data;
    logic                  pxl_rd_en;
    logic [PXL_AW-1:0]     pxl_rd_addr;
    logic [DATA_WIDTH-1:0] pxl_rd_data;
    logic                  valid_weight_in;
    logic [DATA_WIDTH-1:0] weight_in;
    logic                  valid_in;
    logic [DATA_WIDTH-1:0] pxl_in;
    logic [CO_W-1:0]       ch_out_idx;
    logic                  ch_first;
    logic                  ch_last;

    modport master (
        input  start, wgt_rd_data, pxl_rd_data,
        output busy, done, wgt_rd_en, wgt_rd_addr, pxl_rd_en, pxl_rd_addr,
        output valid_weight_in, weight_in, valid_in, pxl_in,
        output ch_out_idx, ch_first, ch_last
    );

    modport slave (
        output start, wgt_rd_data, pxl_rd_data,
        input  busy, done, wgt_rd_en, wgt_rd_addr, pxl_rd_en, pxl_rd_addr,
        input  valid_weight_in, weight_in, valid_in, pxl_in,
        input  ch_out_idx, ch_first, ch_last
    );
endinterface

// File: rtl/conv_3x3_sched.sv
// Layer sequencer for one 3x3 conv tile: for every (co, ci) pair it loads the
// 9 kernel weights, then streams the ci input plane, then idles one cycle.
// Weight addresses are contiguous over the whole layer (co outer, ci inner),
// so a single running address register is enough.
module conv_3x3_sched #(
    parameter int DATA_WIDTH      = 32,
    parameter int IMAGE_WIDTH     = 16,
    parameter int IMAGE_HEIGHT    = 16,
    parameter int CHANNEL_NUM_IN  = 256,
    parameter int CHANNEL_NUM_OUT = 256,
    parameter int KERNEL_SIZE     = 9,
    parameter int PXL_AW          = 16,
    parameter int WGT_AW          = 20
) (
    input logic               clk,
    input logic               reset,
    conv_3x3_sched_if.master  bus
);
    localparam int IMAGE_SIZE = IMAGE_WIDTH * IMAGE_HEIGHT;
    localparam int K_W  = (KERNEL_SIZE     > 1) ? $clog2(KERNEL_SIZE)     : 1;
    localparam int P_W  = (IMAGE_SIZE      > 1) ? $clog2(IMAGE_SIZE)      : 1;
    localparam int CI_W = (CHANNEL_NUM_IN  > 1) ? $clog2(CHANNEL_NUM_IN)  : 1;
    localparam int CO_W = (CHANNEL_NUM_OUT > 1) ? $clog2(CHANNEL_NUM_OUT) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_W = 3'd1,
        S_STREAM = 3'd2,
        S_NEXT   = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [K_W-1:0]      r_k;
    logic [P_W-1:0]      r_p;
    logic [CI_W-1:0]     r_ci;
    logic [CO_W-1:0]     r_co;
    logic [WGT_AW-1:0]   r_wgt_addr;
    logic [PXL_AW-1:0]   r_pxl_addr;
    logic                r_valid_w;
    logic                r_valid_p;
    logic [CO_W-1:0]     r_ch_out_idx;
    logic                r_ch_first;
    logic                r_ch_last;

    logic                w_k_last;
    logic                w_p_last;
    logic                w_ci_first;
    logic                w_ci_last;
    logic                w_co_last;
    logic                w_wgt_rd_en;
    logic                w_pxl_rd_en;

    assign w_k_last    = (r_k  == K_W'(KERNEL_SIZE - 1));
    assign w_p_last    = (r_p  == P_W'(IMAGE_SIZE - 1));
    assign w_ci_first  = (r_ci == {CI_W{1'b0}});
    assign w_ci_last   = (r_ci == CI_W'(CHANNEL_NUM_IN - 1));
    assign w_co_last   = (r_co == CO_W'(CHANNEL_NUM_OUT - 1));
    assign w_wgt_rd_en = (r_state == S_LOAD_W);
    assign w_pxl_rd_en = (r_state == S_STREAM);

    // Next-state decode of the layer FSM.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.start) w_state_nxt = S_LOAD_W;
                else           w_state_nxt = S_IDLE;
            end
            S_LOAD_W: begin
                if (w_k_last) w_state_nxt = S_STREAM;
                else          w_state_nxt = S_LOAD_W;
            end
            S_STREAM: begin
                if (w_p_last) w_state_nxt = S_NEXT;
                else          w_state_nxt = S_STREAM;
            end
            S_NEXT: begin
                if (w_ci_last && w_co_last) w_state_nxt = S_DONE;
                else                        w_state_nxt = S_LOAD_W;
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Kernel/pixel/channel counters and running read addresses.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_k        <= {K_W{1'b0}};
            r_p        <= {P_W{1'b0}};
            r_ci       <= {CI_W{1'b0}};
            r_co       <= {CO_W{1'b0}};
            r_wgt_addr <= {WGT_AW{1'b0}};
            r_pxl_addr <= {PXL_AW{1'b0}};
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_k        <= {K_W{1'b0}};
                        r_p        <= {P_W{1'b0}};
                        r_ci       <= {CI_W{1'b0}};
                        r_co       <= {CO_W{1'b0}};
                        r_wgt_addr <= {WGT_AW{1'b0}};
                        r_pxl_addr <= {PXL_AW{1'b0}};
                    end
                end
                S_LOAD_W: begin
                    r_wgt_addr <= r_wgt_addr + WGT_AW'(1);
                    if (w_k_last) r_k <= {K_W{1'b0}};
                    else          r_k <= r_k + K_W'(1);
                end
                S_STREAM: begin
                    // After the last pixel the address already points at the next plane.
                    r_pxl_addr <= r_pxl_addr + PXL_AW'(1);
                    if (w_p_last) r_p <= {P_W{1'b0}};
                    else          r_p <= r_p + P_W'(1);
                end
                S_NEXT: begin
                    if (!(w_ci_last && w_co_last)) begin
                        if (w_ci_last) begin
                            r_ci       <= {CI_W{1'b0}};
                            r_co       <= r_co + CO_W'(1);
                            r_pxl_addr <= {PXL_AW{1'b0}};
                        end else begin
                            r_ci <= r_ci + CI_W'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Read-return alignment: valids and channel sideband follow the issue cycle by one.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid_w    <= 1'b0;
            r_valid_p    <= 1'b0;
            r_ch_out_idx <= {CO_W{1'b0}};
            r_ch_first   <= 1'b0;
            r_ch_last    <= 1'b0;
        end else begin
            r_valid_w  <= w_wgt_rd_en;
            r_valid_p  <= w_pxl_rd_en;
            r_ch_first <= w_pxl_rd_en && w_ci_first;
            r_ch_last  <= w_pxl_rd_en && w_ci_last;
            if (w_pxl_rd_en) r_ch_out_idx <= r_co;
            else             r_ch_out_idx <= r_ch_out_idx;
        end
    end

    assign bus.busy            = (r_state != S_IDLE);
    assign bus.done            = (r_state == S_DONE);
    assign bus.wgt_rd_en       = w_wgt_rd_en;
    assign bus.wgt_rd_addr     = w_wgt_rd_en ? r_wgt_addr : {WGT_AW{1'b0}};
    assign bus.pxl_rd_en       = w_pxl_rd_en;
    assign bus.pxl_rd_addr     = w_pxl_rd_en ? r_pxl_addr : {PXL_AW{1'b0}};
    assign bus.valid_weight_in = r_valid_w;
    assign bus.valid_in        = r_valid_p;
    // Memory data passes through, masked so stale words never leak outside a valid.
    assign bus.weight_in       = r_valid_w ? bus.wgt_rd_data : {DATA_WIDTH{1'b0}};
    assign bus.pxl_in          = r_valid_p ? bus.pxl_rd_data : {DATA_WIDTH{1'b0}};
    assign bus.ch_out_idx      = r_ch_out_idx;
    assign bus.ch_first        = r_ch_first;
    assign bus.ch_last         = r_ch_last;
endmodule

// File: tb/tb_conv_3x3_sched.sv
// Directed bench for conv_3x3_sched: a 2x2 image, CIN=2/COUT=2 instance and a
// CIN=1/COUT=3 instance, both fed by ramp memories returning addr+100.
`timescale 1ns/1ps
module tb_conv_3x3_sched;
    logic clk;
    logic reset;
    int   sel;
    int   n_cmp;
    int   n_err;

    conv_3x3_sched_if #(.DATA_WIDTH(32), .PXL_AW(16), .WGT_AW(20), .CO_W(1)) if0 ();
    conv_3x3_sched_if #(.DATA_WIDTH(32), .PXL_AW(16), .WGT_AW(20), .CO_W(2)) if1 ();

    conv_3x3_sched #(
        .DATA_WIDTH(32), .IMAGE_WIDTH(2), .IMAGE_HEIGHT(2),
        .CHANNEL_NUM_IN(2), .CHANNEL_NUM_OUT(2), .KERNEL_SIZE(9),
        .PXL_AW(16), .WGT_AW(20)
    ) u_dut0 (.clk(clk), .reset(reset), .bus(if0));

    conv_3x3_sched #(
        .DATA_WIDTH(32), .IMAGE_WIDTH(2), .IMAGE_HEIGHT(2),
        .CHANNEL_NUM_IN(1), .CHANNEL_NUM_OUT(3), .KERNEL_SIZE(9),
        .PXL_AW(16), .WGT_AW(20)
    ) u_dut1 (.clk(clk), .reset(reset), .bus(if1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Ramp memories with one-cycle read latency.
    always @(posedge clk) begin
        if (if0.wgt_rd_en) if0.wgt_rd_data <= 32'(if0.wgt_rd_addr) + 32'd100;
        if (if0.pxl_rd_en) if0.pxl_rd_data <= 32'(if0.pxl_rd_addr) + 32'd100;
        if (if1.wgt_rd_en) if1.wgt_rd_data <= 32'(if1.wgt_rd_addr) + 32'd100;
        if (if1.pxl_rd_en) if1.pxl_rd_data <= 32'(if1.pxl_rd_addr) + 32'd100;
    end

    logic        s_busy, s_done, s_wen, s_pen, s_vw, s_vp, s_first, s_last;
    logic [31:0] s_waddr, s_paddr, s_win, s_pin;
    logic [7:0]  s_idx;

    // Select which instance the checks look at.
    always_comb begin
        if (sel == 0) begin
            s_busy = if0.busy;  s_done = if0.done;
            s_wen = if0.wgt_rd_en; s_waddr = 32'(if0.wgt_rd_addr);
            s_pen = if0.pxl_rd_en; s_paddr = 32'(if0.pxl_rd_addr);
            s_vw = if0.valid_weight_in; s_win = if0.weight_in;
            s_vp = if0.valid_in; s_pin = if0.pxl_in;
            s_first = if0.ch_first; s_last = if0.ch_last; s_idx = 8'(if0.ch_out_idx);
        end else begin
            s_busy = if1.busy;  s_done = if1.done;
            s_wen = if1.wgt_rd_en; s_waddr = 32'(if1.wgt_rd_addr);
            s_pen = if1.pxl_rd_en; s_paddr = 32'(if1.pxl_rd_addr);
            s_vw = if1.valid_weight_in; s_win = if1.weight_in;
            s_vp = if1.valid_in; s_pin = if1.pxl_in;
            s_first = if1.ch_first; s_last = if1.ch_last; s_idx = 8'(if1.ch_out_idx);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic drive_start(input int s, input logic v);
        if (s == 0) if0.start = v;
        else        if1.start = v;
    endtask

    // Expected read issue in cycle c after a start in cycle 0 (2x2 image: 14 cycles per pair).
    task automatic model_issue(input int c, input int cin, input int cout,
                               output bit wen, output int waddr,
                               output bit pen, output int paddr,
                               output int co, output int ci);
        int pair;
        int off;
        wen = 1'b0; pen = 1'b0; waddr = 0; paddr = 0; co = 0; ci = 0;
        if (c >= 1 && c <= cin * cout * 14) begin
            pair = (c - 1) / 14;
            off  = (c - 1) % 14;
            co   = pair / cin;
            ci   = pair % cin;
            if (off < 9) begin
                wen = 1'b1; waddr = pair * 9 + off;
            end else if (off < 13) begin
                pen = 1'b1; paddr = ci * 4 + (off - 9);
            end
        end
    endtask

    // Run one full layer and check every cycle; start is re-pulsed in cycles ign1/ign2.
    task automatic run_layer(input int s, input int cin, input int cout,
                             input int ign1, input int ign2);
        int  last_c;
        int  nw, np, nd;
        bit  wen, pen, pwen, ppen;
        int  waddr, paddr, co, ci, pwaddr, ppaddr, pco, pci;
        last_c = cin * cout * 14 + 1;
        nw = 0; np = 0; nd = 0;
        sel = s;
        @(negedge clk);
        drive_start(s, 1'b1);
        for (int c = 1; c <= last_c + 3; c++) begin
            @(negedge clk);
            drive_start(s, (c == ign1) || (c == ign2));
            #1;
            model_issue(c, cin, cout, wen, waddr, pen, paddr, co, ci);
            model_issue(c - 1, cin, cout, pwen, pwaddr, ppen, ppaddr, pco, pci);
            check_eq($sformatf("L%0d c%0d busy", s, c), 32'(s_busy), 32'(c <= last_c));
            check_eq($sformatf("L%0d c%0d done", s, c), 32'(s_done), 32'(c == last_c));
            check_eq($sformatf("L%0d c%0d wgt_rd_en", s, c), 32'(s_wen), 32'(wen));
            if (wen) check_eq($sformatf("L%0d c%0d wgt_rd_addr", s, c), s_waddr, 32'(waddr));
            check_eq($sformatf("L%0d c%0d pxl_rd_en", s, c), 32'(s_pen), 32'(pen));
            if (pen) check_eq($sformatf("L%0d c%0d pxl_rd_addr", s, c), s_paddr, 32'(paddr));
            check_eq($sformatf("L%0d c%0d valid_weight_in", s, c), 32'(s_vw), 32'(pwen));
            if (pwen) check_eq($sformatf("L%0d c%0d weight_in", s, c), s_win, 32'(pwaddr + 100));
            check_eq($sformatf("L%0d c%0d valid_in", s, c), 32'(s_vp), 32'(ppen));
            check_eq($sformatf("L%0d c%0d ch_first", s, c), 32'(s_first), 32'(ppen && pci == 0));
            check_eq($sformatf("L%0d c%0d ch_last", s, c), 32'(s_last), 32'(ppen && pci == cin - 1));
            if (ppen) begin
                check_eq($sformatf("L%0d c%0d pxl_in", s, c), s_pin, 32'(ppaddr + 100));
                check_eq($sformatf("L%0d c%0d ch_out_idx", s, c), 32'(s_idx), 32'(pco));
            end
            // Hand-picked landmarks of the layer schedule.
            if (cin == 2 && c == 10) check_eq("hand pxl addr0 at c10", s_paddr, 32'd0);
            if (cin == 2 && c == 14) check_eq("hand NEXT idle at c14", 32'({s_wen, s_pen}), 32'd0);
            if (cin == 2 && c == 15) check_eq("hand wbase pair1", s_waddr, 32'd9);
            if (cin == 2 && c == 24) check_eq("hand pbase pair1", s_paddr, 32'd4);
            if (cin == 2 && c == 44) check_eq("hand idx pair2", 32'(s_idx), 32'd1);
            if (cin == 1 && c == 29) check_eq("hand wbase co2", s_waddr, 32'd18);
            if (s_vw)   nw++;
            if (s_vp)   np++;
            if (s_done) nd++;
        end
        drive_start(s, 1'b0);
        check_eq($sformatf("L%0d weight words", s), 32'(nw), 32'(cin * cout * 9));
        check_eq($sformatf("L%0d pixel words", s), 32'(np), 32'(cin * cout * 4));
        check_eq($sformatf("L%0d done pulses", s), 32'(nd), 32'd1);
    endtask

    // Zero checks on the selected instance right after a reset.
    task automatic check_idle(input string tag);
        #1;
        check_eq({tag, " busy"}, 32'(s_busy), 32'd0);
        check_eq({tag, " done"}, 32'(s_done), 32'd0);
        check_eq({tag, " rd_en"}, 32'({s_wen, s_pen}), 32'd0);
        check_eq({tag, " valids"}, 32'({s_vw, s_vp}), 32'd0);
        check_eq({tag, " pxl_in"}, s_pin, 32'd0);
        check_eq({tag, " sideband"}, 32'({s_first, s_last, s_idx}), 32'd0);
    endtask

    initial begin
        n_cmp = 0; n_err = 0; sel = 0;
        reset = 1'b1; if0.start = 1'b0; if1.start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        sel = 0; check_idle("rst dut0");
        sel = 1; check_idle("rst dut1");

        // Full layer with stray starts while busy and in the DONE cycle, then a clean rerun.
        run_layer(0, 2, 2, 20, 57);
        run_layer(0, 2, 2, 0, 0);

        // Abort mid-stream: reset held for one cycle.
        sel = 0;
        @(negedge clk);
        if0.start = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if0.start = 1'b0;
        end
        #1;
        check_eq("abort in stream", 32'(s_pen), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_idle("abort");
        run_layer(0, 2, 2, 0, 0);

        // Single input channel: first and last flags both set on every pixel.
        run_layer(1, 1, 3, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/conv_3x3_sched.md
Name: conv_3x3_sched

Overview:
- Sequencer that drives one 3x3 convolution tile (line buffer, weight buffer, MAC core) through a full layer.
- For every output/input channel pair (co, ci) it does two things in order:
  - fetches the 9 kernel weights from weight memory and streams them on the weight port;
  - then streams the IMAGE_WIDTH*IMAGE_HEIGHT pixels of input channel ci on the pixel port.
- Sits between the layer's feature/weight memories and the conv tile. It provides channel sideband so a downstream accumulator can sum partial results over ci.

Parameters:
DATA_WIDTH, 32, pixel/weight word width
IMAGE_WIDTH, 16, feature map width
IMAGE_HEIGHT, 16, feature map height
CHANNEL_NUM_IN, 256, input channels (CIN)
CHANNEL_NUM_OUT, 256, output channels (COUT)
KERNEL_SIZE, 9, weights per channel pair
PXL_AW, 16, pixel memory address width, must be >= clog2(CIN*IMAGE_WIDTH*IMAGE_HEIGHT)
WGT_AW, 20, weight memory address width, must be >= clog2(COUT*CIN*KERNEL_SIZE)

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle layer start request; only accepted in IDLE
busy  out  1  high from the cycle after an accepted start through the DONE cycle
done  out  1  one-cycle pulse, layer complete
wgt_rd_en  out  1  weight memory read strobe
wgt_rd_addr  out  WGT_AW  weight address = (co*CIN+ci)*KERNEL_SIZE+k
wgt_rd_data  in  DATA_WIDTH  weight data, fixed 1-cycle read latency
pxl_rd_en  out  1  pixel memory read strobe
pxl_rd_addr  out  PXL_AW  pixel address = ci*IMAGE_SIZE+p
pxl_rd_data  in  DATA_WIDTH  pixel data, fixed 1-cycle read latency
valid_weight_in  out  1  weight word valid to conv tile
weight_in  out  DATA_WIDTH  weight word to conv tile
valid_in  out  1  pixel valid to conv tile
pxl_in  out  DATA_WIDTH  pixel to conv tile
ch_out_idx  out  clog2(COUT)  co of the pixel currently on pxl_in
ch_first  out  1  high with valid_in when ci==0
ch_last  out  1  high with valid_in when ci==CIN-1

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset state: all outputs 0, counters 0, FSM in IDLE.
  - Reset asserted mid-layer aborts immediately and drops any in-flight read data.
  - No done pulse is generated for an aborted layer.
- IMAGE_SIZE = IMAGE_WIDTH*IMAGE_HEIGHT.
- Counters: k (0..KERNEL_SIZE-1), p (0..IMAGE_SIZE-1), ci, co.
- FSM states:
  - IDLE: start=1 moves to LOAD_W; co, ci, k and p are cleared. start while not IDLE is ignored.
  - LOAD_W: wgt_rd_en=1 for exactly KERNEL_SIZE cycles, addresses base+0..base+8. After k==KERNEL_SIZE-1, moves to STREAM.
  - STREAM: pxl_rd_en=1 for exactly IMAGE_SIZE cycles, addresses ci*IMAGE_SIZE+0..+IMAGE_SIZE-1. After p==IMAGE_SIZE-1, moves to NEXT.
  - NEXT: one cycle with no reads.
    - If ci==CIN-1 and co==COUT-1, moves to DONE.
    - Otherwise ci increments. When ci wraps from CIN-1 to 0, co increments. Then moves to LOAD_W.
  - DONE: done=1 for one cycle, busy=1, then IDLE.
- Read-return path: valid_weight_in and valid_in are wgt_rd_en and pxl_rd_en delayed one cycle. weight_in and pxl_in are the memory data passed through unregistered, aligned with those valids.
- Sideband: ch_out_idx, ch_first and ch_last are registered copies of the issue-time co/ci, aligned to valid_in.
- No back-pressure.
- Per-pair timing:
  - Each pair takes KERNEL_SIZE+IMAGE_SIZE+1 cycles.
  - The last weight lands one cycle before the first pixel.
  - The NEXT cycle leaves one idle cycle on valid_in between pairs.
- Whole-layer timing:
  - Total layer length from accepted start to done = 1 + COUT*CIN*(KERNEL_SIZE+IMAGE_SIZE+1) cycles.
  - done is asserted the cycle after the final valid_in.
- Degenerate CIN=1: ch_first and ch_last are both high for every pixel.

Test Plan:
1. Reset mid-STREAM, held 1 cycle -> next cycle: busy=0, all valids 0; a new start restarts at wgt_rd_addr=0.
2. Small config (IW=2, IH=2, CIN=2, COUT=2), start at cycle 0:
   - wgt_rd_en cycles 1-9, addr 0-8; valid_weight_in cycles 2-10;
   - pxl_rd_en cycles 10-13, addr 0-3; valid_in cycles 11-14;
   - NEXT at cycle 14, then wgt_rd_addr 9-17 and pxl_rd_addr 4-7;
   - done at cycle 57.
3. Same config: check ch_first=1 only on pixels of ci=0, ch_last=1 only on ci=1, and ch_out_idx switches 0->1 on the third pair.
4. start pulsed again during busy and during DONE -> ignored; exactly one done pulse; second start after IDLE runs a full identical layer.
5. Memory returns ramp data (addr+100) -> weight_in/pxl_in equal expected value exactly on valid cycles, with no dropped or duplicated words over a full layer.
6. CIN=1, COUT=3 -> ch_first=ch_last=1 on every valid_in; ch_out_idx 0,1,2; wgt_rd_addr bases 0, 9, 18.
